// File: rtl/reg_resp_pkg.sv
// Shared types and constants for the register-access responder.
package reg_resp_pkg;

  // Default bus width used by the response record type.
  localparam int unsigned RESP_DW = 32;

  // One buffered response: error flag above the read data.
  typedef struct packed {
    logic               err;
    logic [RESP_DW-1:0] rdata;
  } resp_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Identification word returned by register 0.
  localparam logic [31:0] ID_DEFAULT = 32'h0D71_0001;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous circular buffer holding responses in acceptance order.
module resp_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop;

  // Status flags and head entry come straight from registered state.
  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = mem_q[head_q];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Pointer, count and storage next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[tail_q] = wdata_i;
      tail_d        = tail_q + PtrW'(1);
    end
    if (do_pop) begin
      head_d = head_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves the count unchanged.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/reg_responder.sv
// Register-access target: decodes request beats against a small register
// bank and queues one in-order response per accepted request.
module reg_responder
  import reg_resp_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 12,
  parameter int unsigned           RESP_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(ID_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic [$clog2(RESP_DEPTH):0]   resp_count
);

  localparam int unsigned EntW = DATA_WIDTH + 1;

  logic                  rst_n_q, rst_n_d;
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  logic                  req_accept;
  logic                  addr_hit;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  ent_err;
  logic [DATA_WIDTH-1:0] ent_rdata;
  logic [EntW-1:0]       fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic                  resp_pop;

  // Delayed reset keeps req_ready low on the first cycle out of reset.
  always_comb begin
    rst_n_d = 1'b1;
  end

  // Registered reset-release flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q <= 1'b0;
    end else begin
      rst_n_q <= rst_n_d;
    end
  end

  // Handshakes depend only on registered state, never on resp_ready.
  always_comb begin
    req_ready  = rst_n_q && !fifo_full;
    req_accept = req_valid && req_ready;
    resp_valid = !fifo_empty;
    resp_pop   = resp_valid && resp_ready;
  end

  // Address decode, register update and response formation.
  always_comb begin
    regs_d    = regs_q;
    addr_hit  = 1'b0;
    reg_rdata = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_WIDTH'(i)) begin
        addr_hit  = 1'b1;
        reg_rdata = regs_q[i];
        if (req_accept && req_write) begin
          regs_d[i] = req_wdata;
        end
      end
    end

    ent_rdata = '0;
    ent_err   = RESP_ERR;
    if (req_write) begin
      // Register 0 is read-only, so only the bank range accepts writes.
      ent_err = addr_hit ? RESP_OK : RESP_ERR;
    end else if (req_addr == '0) begin
      ent_rdata = ID_VALUE;
      ent_err   = RESP_OK;
    end else if (addr_hit) begin
      ent_rdata = reg_rdata;
      ent_err   = RESP_OK;
    end
  end

  // Register bank with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  resp_fifo #(
    .Width (EntW),
    .Depth (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (req_accept),
    .wdata_i ({ent_err, ent_rdata}),
    .pop_i   (resp_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (resp_count)
  );

  // Head entry is masked to zero whenever nothing is buffered.
  always_comb begin
    resp_rdata = resp_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
    resp_err   = resp_valid && fifo_rdata[DATA_WIDTH];
  end

endmodule

// File: tb/tb_reg_responder.sv
// Directed self-checking bench for reg_responder.
module tb_reg_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  resp_count;

  int unsigned n_cmp;
  int unsigned n_bad;

  localparam logic [31:0] Id = 32'h0D71_0001;

  reg_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_count (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] d, input logic e,
                          input logic [2:0] c);
    chk({tag, ".valid"}, 64'(resp_valid), 64'(v));
    chk({tag, ".rdata"}, 64'(resp_rdata), 64'(d));
    chk({tag, ".err"},   64'(resp_err),   64'(e));
    chk({tag, ".count"}, 64'(resp_count), 64'(c));
  endtask

  task automatic set_req(input logic w, input logic [3:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset then idle.
    repeat (3) cyc();
    chk("rst.req_ready", 64'(req_ready), 64'(0));
    chk_head("rst", 1'b0, 32'h0, 1'b0, 3'd0);
    rst_n = 1'b1;
    cyc();
    chk("rel.req_ready", 64'(req_ready), 64'(1));
    chk("rel.count", 64'(resp_count), 64'(0));

    // Write then read back addr 5.
    resp_ready = 1'b1;
    set_req(1'b1, 4'd5, 32'hCAFE_F00D);
    cyc();
    chk_head("wr5", 1'b1, 32'h0, 1'b0, 3'd1);
    set_req(1'b0, 4'd5, 32'h0);
    cyc();
    chk_head("rd5", 1'b1, 32'hCAFE_F00D, 1'b0, 3'd1);
    req_valid = 1'b0;
    cyc();
    chk_head("drain1", 1'b0, 32'h0, 1'b0, 3'd0);

    // ID register and error decode.
    set_req(1'b0, 4'd0, 32'h0);
    cyc();
    chk_head("rd0", 1'b1, Id, 1'b0, 3'd1);
    set_req(1'b1, 4'd0, 32'h0000_1234);
    cyc();
    chk_head("wr0", 1'b1, 32'h0, 1'b1, 3'd1);
    set_req(1'b0, 4'd0, 32'h0);
    cyc();
    chk_head("rd0b", 1'b1, Id, 1'b0, 3'd1);
    set_req(1'b0, 4'd12, 32'h0);
    cyc();
    chk_head("rd12", 1'b1, 32'h0, 1'b1, 3'd1);
    set_req(1'b0, 4'd15, 32'h0);
    cyc();
    chk_head("rd15", 1'b1, 32'h0, 1'b1, 3'd1);
    set_req(1'b1, 4'd12, 32'hFFFF_FFFF);
    cyc();
    chk_head("wr12", 1'b1, 32'h0, 1'b1, 3'd1);
    set_req(1'b0, 4'd5, 32'h0);
    cyc();
    chk_head("rd5b", 1'b1, 32'hCAFE_F00D, 1'b0, 3'd1);
    req_valid = 1'b0;
    cyc();
    chk_head("drain2", 1'b0, 32'h0, 1'b0, 3'd0);

    // Preload regs 1..6 with 0x101..0x106.
    for (int i = 1; i <= 6; i++) begin
      set_req(1'b1, 4'(i), 32'h100 + 32'(i));
      cyc();
    end
    req_valid = 1'b0;
    cyc();
    chk("pre.count", 64'(resp_count), 64'(0));

    // Backpressure: fill the buffer with reads of 1..4.
    resp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b0, 4'(i), 32'h0);
      cyc();
    end
    chk("bp.full.req_ready", 64'(req_ready), 64'(0));
    chk_head("bp.full", 1'b1, 32'h101, 1'b0, 3'd4);
    set_req(1'b0, 4'd5, 32'h0);
    cyc();
    chk("bp.stall.req_ready", 64'(req_ready), 64'(0));
    chk_head("bp.stall", 1'b1, 32'h101, 1'b0, 3'd4);
    // Pop cycle: ready must stay low until the pop has happened.
    resp_ready = 1'b1;
    #1;
    chk("bp.popcyc.req_ready", 64'(req_ready), 64'(0));
    cyc();
    chk("bp.after.req_ready", 64'(req_ready), 64'(1));
    chk_head("bp.after", 1'b1, 32'h102, 1'b0, 3'd3);
    cyc();
    chk_head("bp.r3", 1'b1, 32'h103, 1'b0, 3'd3);
    set_req(1'b0, 4'd6, 32'h0);
    cyc();
    chk_head("bp.r4", 1'b1, 32'h104, 1'b0, 3'd3);
    req_valid = 1'b0;
    cyc();
    chk_head("bp.r5", 1'b1, 32'h105, 1'b0, 3'd2);
    cyc();
    chk_head("bp.r6", 1'b1, 32'h106, 1'b0, 3'd1);
    cyc();
    chk_head("bp.empty", 1'b0, 32'h0, 1'b0, 3'd0);

    // Reset mid-stream with three responses buffered.
    resp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_req(1'b0, 4'(i), 32'h0);
      cyc();
    end
    chk("mr.pre.count", 64'(resp_count), 64'(3));
    req_valid = 1'b0;
    rst_n     = 1'b0;
    cyc();
    chk("mr.req_ready", 64'(req_ready), 64'(0));
    chk_head("mr.rst", 1'b0, 32'h0, 1'b0, 3'd0);
    rst_n = 1'b1;
    cyc();
    chk("mr.rel.req_ready", 64'(req_ready), 64'(1));
    resp_ready = 1'b1;
    set_req(1'b0, 4'd5, 32'h0);
    cyc();
    chk_head("mr.rd5", 1'b1, 32'h0, 1'b0, 3'd1);
    set_req(1'b0, 4'd1, 32'h0);
    cyc();
    chk_head("mr.rd1", 1'b1, 32'h0, 1'b0, 3'd1);
    req_valid = 1'b0;
    cyc();
    chk_head("mr.empty", 1'b0, 32'h0, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
